// File: rtl/dac_i2c_pkg.sv
// Shared types and constants for the MCP4725 I2C streaming master.
package dac_i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_ADDR,
    ST_ACK0,
    ST_CMD,
    ST_ACK1,
    ST_DATA,
    ST_ACK2,
    ST_STOP
  } state_t;

  localparam int SLOT_QTICKS = 4;
  localparam int FRAME_SLOTS = 29;

  // MCP4725 fast-write first data byte: {C2:C1 = 00, PD1:PD0, D11:D8}
  localparam logic [1:0] FW_CMD_TYPE  = 2'b00;
  localparam int         FW_CODE_HI_W = 4;

  function automatic logic [7:0] fw_cmd_byte(input logic [1:0] pd,
                                             input logic [FW_CODE_HI_W-1:0] code_hi);
    return {FW_CMD_TYPE, pd, code_hi};
  endfunction

endpackage

// File: rtl/dac_i2c_streamer_if.sv
// Control and pin bundle between the sample source / board pins and the streamer.
interface dac_i2c_streamer_if #(
  parameter int SAMPLE_W = 32
);
  logic                enable;
  logic [SAMPLE_W-1:0] sample;
  logic                clear_err;
  logic                sda_in;
  logic                scl_oe;
  logic                sda_oe;
  logic                busy;
  logic                frame_done;
  logic                nack_error;

  modport master (
    input  enable, sample, clear_err, sda_in,
    output scl_oe, sda_oe, busy, frame_done, nack_error
  );

  modport slave (
    output enable, sample, clear_err, sda_in,
    input  scl_oe, sda_oe, busy, frame_done, nack_error
  );
endinterface

// File: rtl/dac_i2c_streamer_qtick_gen.sv
// SCL quarter-phase timebase: free-running CLK_DIV divider plus a quarter index
// that only advances while a frame is running (held at 0 while idle).
module i2c_qtick_gen #(
  parameter int CLK_DIV = 25
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_run,
  output logic       o_qtick,
  output logic [1:0] o_quarter
);
  localparam int                CNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_quarter;

  assign o_qtick   = (r_cnt == CNT_MAX);
  assign o_quarter = r_quarter;

  // Divider counts 0..CLK_DIV-1 and wraps; qtick marks the wrap cycle.
  always_ff @(posedge clk) begin
    if (reset)        r_cnt <= '0;
    else if (o_qtick) r_cnt <= '0;
    else              r_cnt <= r_cnt + 1'b1;
  end

  // Quarter index within the current bit slot.
  always_ff @(posedge clk) begin
    if (reset || !i_run) r_quarter <= 2'd0;
    else if (o_qtick)    r_quarter <= r_quarter + 2'd1;
  end
endmodule

// File: rtl/dac_i2c_streamer.sv
// Streams one latched sample per frame to an MCP4725-class DAC as an I2C
// fast-mode write (START, addr+W, cmd/code-high, code-low, STOP).
// The IDLE qtick that latches a frame doubles as q0 of the START slot, so
// back-to-back frames repeat every 116 qticks.
module dac_i2c_streamer
  import dac_i2c_pkg::*;
#(
  parameter int         CLK_DIV   = 25,
  parameter logic [6:0] DEV_ADDR  = 7'h60,
  parameter int         SAMPLE_W  = 32,
  parameter int         DAC_W     = 12,
  parameter bit         SIGNED_IN = 1'b0,
  parameter logic [1:0] PD_BITS   = 2'b00
) (
  input logic                clk,
  input logic                reset,
  dac_i2c_streamer_if.master bus
);
  state_t             r_state, w_state_nxt;
  logic               w_qtick, w_last_q;
  logic [1:0]         w_quarter;
  logic [7:0]         r_shift;
  logic [2:0]         r_bit;
  logic [DAC_W-1:0]   r_code, w_code_in;
  logic               r_scl_oe, r_sda_oe, w_scl_oe_nxt, w_sda_oe_nxt;
  logic               r_frame_done, r_nack_error, r_nack_frame;
  logic               w_unused_lsbs;

  i2c_qtick_gen #(.CLK_DIV(CLK_DIV)) u_qtick (
    .clk       (clk),
    .reset     (reset),
    .i_run     ((r_state != ST_IDLE) || bus.enable),
    .o_qtick   (w_qtick),
    .o_quarter (w_quarter)
  );

  assign w_last_q      = (w_quarter == 2'd3);
  assign w_code_in     = bus.sample[SAMPLE_W-1 -: DAC_W] ^ {SIGNED_IN, {(DAC_W-1){1'b0}}};
  assign w_unused_lsbs = ^bus.sample[SAMPLE_W-DAC_W-1:0];

  assign bus.scl_oe     = r_scl_oe;
  assign bus.sda_oe     = r_sda_oe;
  assign bus.busy       = (r_state != ST_IDLE);
  assign bus.frame_done = r_frame_done;
  assign bus.nack_error = r_nack_error;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Slot sequencing; a NACK in any ACK slot diverts straight to STOP.
  always_comb begin
    w_state_nxt = r_state;
    if (w_qtick) begin
      case (r_state)
        ST_IDLE:  if (bus.enable) w_state_nxt = ST_START;
        ST_START: if (w_last_q) w_state_nxt = ST_ADDR;
        ST_ADDR:  if (w_last_q && r_bit == 3'd0) w_state_nxt = ST_ACK0;
        ST_ACK0:  if (w_last_q) w_state_nxt = bus.sda_in ? ST_STOP : ST_CMD;
        ST_CMD:   if (w_last_q && r_bit == 3'd0) w_state_nxt = ST_ACK1;
        ST_ACK1:  if (w_last_q) w_state_nxt = bus.sda_in ? ST_STOP : ST_DATA;
        ST_DATA:  if (w_last_q && r_bit == 3'd0) w_state_nxt = ST_ACK2;
        ST_ACK2:  if (w_last_q) w_state_nxt = ST_STOP;
        ST_STOP:  if (w_last_q) w_state_nxt = ST_IDLE;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Next pin drive per slot and quarter (1 = pull low).
  always_comb begin
    w_scl_oe_nxt = r_scl_oe;
    w_sda_oe_nxt = r_sda_oe;
    if (w_qtick) begin
      case (r_state)
        ST_IDLE: begin
          w_scl_oe_nxt = 1'b0;
          w_sda_oe_nxt = 1'b0;
        end
        ST_START: begin
          case (w_quarter)
            2'd2:    w_sda_oe_nxt = 1'b1;
            2'd3:    w_scl_oe_nxt = 1'b1;
            default: begin
              w_scl_oe_nxt = 1'b0;
              w_sda_oe_nxt = 1'b0;
            end
          endcase
        end
        ST_ADDR, ST_CMD, ST_DATA: begin
          case (w_quarter)
            2'd0: begin
              w_scl_oe_nxt = 1'b1;
              w_sda_oe_nxt = ~r_shift[7];
            end
            2'd2:    w_scl_oe_nxt = 1'b0;
            default: begin end
          endcase
        end
        ST_ACK0, ST_ACK1, ST_ACK2: begin
          case (w_quarter)
            2'd0: begin
              w_scl_oe_nxt = 1'b1;
              w_sda_oe_nxt = 1'b0;
            end
            2'd2:    w_scl_oe_nxt = 1'b0;
            default: begin end
          endcase
        end
        ST_STOP: begin
          case (w_quarter)
            2'd0: begin
              w_scl_oe_nxt = 1'b1;
              w_sda_oe_nxt = 1'b1;
            end
            2'd1:    w_scl_oe_nxt = 1'b0;
            2'd3:    w_sda_oe_nxt = 1'b0;
            default: begin end
          endcase
        end
        default: begin
          w_scl_oe_nxt = 1'b0;
          w_sda_oe_nxt = 1'b0;
        end
      endcase
    end
  end

  // Registered open-drain enables.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_scl_oe <= 1'b0;
      r_sda_oe <= 1'b0;
    end else begin
      r_scl_oe <= w_scl_oe_nxt;
      r_sda_oe <= w_sda_oe_nxt;
    end
  end

  // Code latch, byte shifter, bit counter and status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_code       <= '0;
      r_shift      <= '0;
      r_bit        <= '0;
      r_frame_done <= 1'b0;
      r_nack_error <= 1'b0;
      r_nack_frame <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (bus.clear_err) r_nack_error <= 1'b0;
      if (w_qtick) begin
        case (r_state)
          ST_IDLE: if (bus.enable) begin
            r_code       <= w_code_in;
            r_shift      <= {DEV_ADDR, 1'b0};
            r_bit        <= 3'd7;
            r_nack_frame <= 1'b0;
          end
          ST_ADDR, ST_CMD, ST_DATA: if (w_last_q) begin
            r_shift <= {r_shift[6:0], 1'b0};
            r_bit   <= r_bit - 3'd1;
          end
          ST_ACK0, ST_ACK1, ST_ACK2: if (w_last_q) begin
            if (bus.sda_in) begin
              r_nack_error <= 1'b1;
              r_nack_frame <= 1'b1;
            end else if (r_state == ST_ACK0) begin
              r_shift <= fw_cmd_byte(PD_BITS, r_code[DAC_W-1 -: FW_CODE_HI_W]);
            end else begin
              r_shift <= r_code[7:0];
            end
          end
          ST_STOP: if (w_last_q) r_frame_done <= ~r_nack_frame;
          default: begin end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_dac_i2c_streamer.sv
// Directed bench: two streamers (unsigned and signed input) share one I2C
// slave model selected by 'sel'; the model decodes frames and ACKs/NACKs.
module tb_dac_i2c_streamer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sel = 1'b0;
  logic pull = 1'b0;
  int   nack_byte = -1;
  int   cyc = 0;

  int   n_chk = 0;
  int   n_err = 0;

  int          start_cnt = 0, stop_cnt = 0, done_a = 0, done_b = 0;
  int          last_done_cyc = 0, prev_done_cyc = 0;
  int          bitcnt = 0, byte_idx = 0;
  logic [7:0]  shreg = 8'h00;
  logic [7:0]  rx0 = 8'h00, rx1 = 8'h00, rx2 = 8'h00;
  logic [31:0] last_frame = 32'h0;
  logic        p_scl = 1'b1, p_sda = 1'b1, scl_m, sda_m;
  logic        set_win_seen = 1'b0;
  int          st_snap, d_snap;

  dac_i2c_streamer_if #(.SAMPLE_W(32)) if_a ();
  dac_i2c_streamer_if #(.SAMPLE_W(32)) if_b ();

  dac_i2c_streamer #(.CLK_DIV(4), .DEV_ADDR(7'h60), .SAMPLE_W(32), .DAC_W(12),
                     .SIGNED_IN(1'b0), .PD_BITS(2'b00)) u_dut_a (
    .clk(clk), .reset(reset), .bus(if_a.master));

  dac_i2c_streamer #(.CLK_DIV(4), .DEV_ADDR(7'h60), .SAMPLE_W(32), .DAC_W(12),
                     .SIGNED_IN(1'b1), .PD_BITS(2'b00)) u_dut_b (
    .clk(clk), .reset(reset), .bus(if_b.master));

  assign if_a.sda_in = ~(if_a.sda_oe | (pull & ~sel));
  assign if_b.sda_in = ~(if_b.sda_oe | (pull & sel));

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Slave model: open-drain resolution, START/STOP detection, byte capture, ACK drive.
  always @(negedge clk) begin
    scl_m = sel ? ~if_b.scl_oe : ~if_a.scl_oe;
    sda_m = (sel ? ~if_b.sda_oe : ~if_a.sda_oe) & ~pull;
    if (p_scl && scl_m && p_sda && !sda_m) begin
      start_cnt++;
      bitcnt = 0; byte_idx = 0; shreg = 8'h00;
      rx0 = 8'h00; rx1 = 8'h00; rx2 = 8'h00;
      pull = 1'b0;
    end else if (p_scl && scl_m && !p_sda && sda_m) begin
      stop_cnt++;
      last_frame = {8'(byte_idx), rx0, rx1, rx2};
    end else if (!p_scl && scl_m) begin
      if (bitcnt < 8) begin
        shreg = {shreg[6:0], sda_m};
        bitcnt++;
        if (bitcnt == 8) begin
          case (byte_idx)
            0: rx0 = shreg;
            1: rx1 = shreg;
            2: rx2 = shreg;
            default: begin end
          endcase
          byte_idx++;
        end
      end else begin
        bitcnt = 0;
      end
    end else if (p_scl && !scl_m) begin
      pull = (bitcnt == 8) && ((byte_idx - 1) != nack_byte);
    end
    p_scl = scl_m;
    p_sda = sda_m;
    if (if_a.frame_done) begin
      done_a++;
      prev_done_cyc = last_done_cyc;
      last_done_cyc = cyc;
    end
    if (if_b.frame_done) done_b++;
    if (if_a.clear_err && if_a.nack_error) set_win_seen = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    end
  endtask

  function automatic int probe(input int which);
    case (which)
      0: return done_a;
      1: return done_b;
      2: return stop_cnt;
      3: return int'(if_a.busy);
      default: return 0;
    endcase
  endfunction

  task automatic wait_for(input int which, input int target, input int budget, input string tag);
    int n;
    n = 0;
    while (probe(which) != target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_reached"}, (probe(which) == target) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_scl_oe"}, 32'(if_a.scl_oe), 32'd0);
    chk({tag, "_sda_oe"}, 32'(if_a.sda_oe), 32'd0);
    chk({tag, "_busy"}, 32'(if_a.busy), 32'd0);
    chk({tag, "_frame_done"}, 32'(if_a.frame_done), 32'd0);
    chk({tag, "_nack_error"}, 32'(if_a.nack_error), 32'd0);
  endtask

  initial begin
    if_a.enable = 1'b0; if_a.sample = 32'h0; if_a.clear_err = 1'b0;
    if_b.enable = 1'b0; if_b.sample = 32'h0; if_b.clear_err = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");

    // Happy path and back-to-back period
    if_a.sample = 32'hABC0_0000;
    if_a.enable = 1'b1;
    reset = 1'b0;
    wait_for(0, 1, 1200, "t1_done1");
    chk("t1_frame1", last_frame, 32'h03C0_0ABC);
    wait_for(0, 2, 1200, "t1_done2");
    chk("t1_frame2", last_frame, 32'h03C0_0ABC);
    chk("t1_period", 32'(last_done_cyc - prev_done_cyc), 32'd464);
    chk("t1_nack", 32'(if_a.nack_error), 32'd0);

    // Sample change mid-frame only affects the next frame
    repeat (200) @(negedge clk);
    if_a.sample = 32'h1230_0000;
    wait_for(0, 3, 1200, "t2_done3");
    chk("t2_inflight", last_frame, 32'h03C0_0ABC);
    wait_for(0, 4, 1200, "t2_done4");
    chk("t2_next", last_frame, 32'h03C0_0123);

    // NACK on address: STOP after ACK0, sticky error, no frame_done
    nack_byte = 0;
    st_snap = stop_cnt;
    wait_for(2, st_snap + 1, 1200, "t3_stop");
    chk("t3_nbytes", last_frame, 32'h01C0_0000);
    chk("t3_nack_set", 32'(if_a.nack_error), 32'd1);
    chk("t3_no_done", 32'(done_a), 32'd4);
    if_a.clear_err = 1'b1;
    @(negedge clk);
    if_a.clear_err = 1'b0;
    chk("t3_cleared", 32'(if_a.nack_error), 32'd0);
    // clear held through the next NACK: the set must still win that cycle
    if_a.clear_err = 1'b1;
    set_win_seen = 1'b0;
    st_snap = stop_cnt;
    wait_for(2, st_snap + 1, 1200, "t3_stop2");
    chk("t3_set_wins", 32'(set_win_seen), 32'd1);
    @(negedge clk);
    chk("t3_held_clear", 32'(if_a.nack_error), 32'd0);
    chk("t3_no_done2", 32'(done_a), 32'd4);
    if_a.clear_err = 1'b0;
    nack_byte = -1;

    // Enable dropped during DATA: frame completes, then bus stays idle
    wait_for(3, 1, 100, "t4_busy");
    repeat (340) @(negedge clk);
    if_a.enable = 1'b0;
    d_snap = done_a;
    wait_for(0, d_snap + 1, 600, "t4_done");
    chk("t4_frame", last_frame, 32'h03C0_0123);
    st_snap = start_cnt;
    repeat (600) @(negedge clk);
    chk("t4_busy_low", 32'(if_a.busy), 32'd0);
    chk("t4_scl_rel", 32'(if_a.scl_oe), 32'd0);
    chk("t4_sda_rel", 32'(if_a.sda_oe), 32'd0);
    chk("t4_no_start", 32'(start_cnt), 32'(st_snap));
    chk("t4_no_done", 32'(done_a), 32'(d_snap + 1));

    // Reset during CMD aborts at once; a clean frame follows
    if_a.enable = 1'b1;
    wait_for(3, 1, 100, "t5_busy");
    repeat (200) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_idle_outputs("t5_reset");
    @(negedge clk);
    reset = 1'b0;
    st_snap = start_cnt;
    d_snap = done_a;
    wait_for(0, d_snap + 1, 1200, "t5_done");
    chk("t5_one_start", 32'(start_cnt), 32'(st_snap + 1));
    chk("t5_frame", last_frame, 32'h03C0_0123);

    // Signed input on the second instance
    if_a.enable = 1'b0;
    wait_for(3, 0, 600, "t6_a_idle");
    @(negedge clk);
    sel = 1'b1;
    if_b.sample = 32'h8000_0000;
    if_b.enable = 1'b1;
    wait_for(1, 1, 1200, "t6_done1");
    chk("t6_min", last_frame, 32'h03C0_0000);
    if_b.sample = 32'h7FF0_0000;
    wait_for(1, 2, 1200, "t6_done2");
    chk("t6_max", last_frame, 32'h03C0_0FFF);
    if_b.enable = 1'b0;
    repeat (10) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
